sprite_line_scheduler: RTL and testbench
========================================

Name: sprite_line_scheduler

Overview:
- Per-pixel scheduler that drives the color mapper.
- During horizontal blanking it scans all sprites (pacman + 4 ghosts) against the upcoming line and builds a priority-ordered active list.
- During active video it selects, for each pixel, the entity code, sprite-relative and maze-relative addresses, and direction.
- It sits between game logic (sprite positions) and the color mapper.

Parameters:
- NUM_SPRITES, 5, sprite count; index 0 = pacman, 1..4 = blinky, pinky, inky, clyde
- MAX_PER_LINE, 4, active-list slots per line
- SPRITE_W, 16, sprite width in pixels
- SPRITE_H, 16, sprite height in pixels
- MAZE_X0, 96, maze left edge in screen X
- MAZE_Y0, 0, maze top edge in screen Y
- MAZE_W, 448, maze width in pixels
- MAZE_H, 480, maze height in pixels

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse at vblank; latches sprite shadow registers
- line_start  in  1  one-cycle pulse at start of hblank; begins a scan for line_y
- line_y  in  10  screen line being prepared
- DrawX, DrawY  in  10 each  current pixel coordinates
- spr_x  in  10*NUM_SPRITES  packed sprite left X
- spr_y  in  10*NUM_SPRITES  packed sprite top Y
- spr_dir  in  2*NUM_SPRITES  packed direction (0 up, 1 left, 2 down, 3 right)
- spr_en  in  NUM_SPRITES  sprite visible
- entity  out  7  0 outside maze, 1 pacman, 2 background, 3..6 ghosts
- spriteAddrX, spriteAddrY  out  10 each  pixel offset inside the selected sprite
- mazeAddrX, mazeAddrY  out  10 each  pixel offset inside the maze
- direction  out  2  direction of the selected sprite
- sched_busy  out  1  high while in SCAN
- line_overflow  out  1  sticky; more than MAX_PER_LINE sprites hit a line

Behaviour:
- One clock (Clk). Reset is synchronous and active-high.
- Reset: all outputs 0, state IDLE, active list empty, shadow registers 0, spr_en shadow 0.
- Shadow registers:
  - On frame_start, latch spr_x, spr_y, spr_dir and spr_en.
  - All scans use the shadow copies only. Live inputs may change at any time without affecting the frame.
- States:
  - IDLE: wait for line_start.
  - SCAN: entered on line_start. Clears the list, latches line_y, sets sprite index i=0.
    - Each cycle, test sprite i. Hit = en && line_y >= y && line_y < y+SPRITE_H, computed at 11 bits (no wrap).
    - On hit with list count < MAX_PER_LINE: append {x, dir, row = line_y - y (4 bits), entity code}. Entity code = 1 for i=0, i+2 otherwise.
    - On hit with the list full: set line_overflow and drop the sprite.
    - After i = NUM_SPRITES-1, go to READY. SCAN takes exactly NUM_SPRITES cycles.
  - READY: list is valid; go to SCAN on the next line_start.
- line_start during SCAN: restart the scan (list cleared, i=0, new line_y latched).
- line_start and frame_start in the same cycle: the shadow latch takes effect first; that scan uses the new values.
- line_overflow clears on frame_start, unless the same cycle sets it.
- Pixel path (registered, latency 1 cycle from DrawX/DrawY to outputs):
  - Outside maze (DrawX < MAZE_X0, DrawX >= MAZE_X0+MAZE_W, DrawY < MAZE_Y0, or DrawY >= MAZE_Y0+MAZE_H): entity=0, all addresses 0, direction 0.
  - Inside maze: mazeAddrX = DrawX-MAZE_X0, mazeAddrY = DrawY-MAZE_Y0.
  - In READY, test each valid slot in parallel: DrawX >= slot_x && DrawX < slot_x+SPRITE_W, at 11 bits.
  - Lowest-index hitting slot wins. Pacman has highest priority, then ghosts in index order.
  - On a hit: entity = slot code, spriteAddrX = DrawX-slot_x, spriteAddrY = slot row, direction = slot dir.
  - No hit, or state is not READY: entity=2, spriteAddrX/Y=0, direction=0.
- Sprites partly off the left maze edge need no special handling: the comparisons are at screen coordinates, and clipping is by the maze test.
- Reset mid-SCAN: returns to IDLE next cycle with the list empty. Pixel outputs follow the rules above (entity 2 inside maze).

Test Plan:
- Reset, then drive DrawX=100, DrawY=10 -> one cycle later: entity=2, mazeAddrX=4, mazeAddrY=10, sched_busy=0, line_overflow=0.
- Pacman at (200,40) dir=3, enabled, frame_start; line_start with line_y=45 -> sched_busy high exactly 5 cycles. Then DrawX=205 -> entity=1, spriteAddrX=5, spriteAddrY=5, direction=3. DrawX=216 -> entity=2.
- Pacman and blinky both at (300,100), dir 0 and 1; scan line_y=100 -> at DrawX=300: entity=1, direction=0 (priority). With pacman disabled: entity=3, direction=1.
- All 5 sprites at y=50, x=120,140,160,180,200; scan line_y=50 -> line_overflow=1. DrawX=205 -> entity=2 (clyde dropped). DrawX=185 -> entity=5. Next frame_start with sprites moved -> line_overflow=0.
- line_start at line_y=60, second line_start with line_y=61 after 2 cycles -> SCAN restarts: sched_busy high 5 more cycles, list reflects line 61. Live spr_x changes without frame_start -> no effect.
- DrawX=50 (outside maze) with a sprite at x=40 -> entity=0, addresses 0. Assert Reset mid-SCAN -> sched_busy=0 next cycle; inside-maze pixels give entity=2.

Source files
------------

// File: rtl/sprite_line_scheduler.sv
// Sprite line scheduler: builds a per-line active sprite list in hblank
// and resolves the entity and addresses for each pixel during active video.
module sprite_line_scheduler #(
    parameter int NUM_SPRITES  = 5,
    parameter int MAX_PER_LINE = 4,
    parameter int SPRITE_W     = 16,
    parameter int SPRITE_H     = 16,
    parameter int MAZE_X0      = 96,
    parameter int MAZE_Y0      = 0,
    parameter int MAZE_W       = 448,
    parameter int MAZE_H       = 480
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     frame_start,
    input  logic                     line_start,
    input  logic [9:0]               line_y,
    input  logic [9:0]               DrawX,
    input  logic [9:0]               DrawY,
    input  logic [10*NUM_SPRITES-1:0] spr_x,
    input  logic [10*NUM_SPRITES-1:0] spr_y,
    input  logic [2*NUM_SPRITES-1:0] spr_dir,
    input  logic [NUM_SPRITES-1:0]   spr_en,
    output logic [6:0]               entity,
    output logic [9:0]               spriteAddrX,
    output logic [9:0]               spriteAddrY,
    output logic [9:0]               mazeAddrX,
    output logic [9:0]               mazeAddrY,
    output logic [1:0]               direction,
    output logic                     sched_busy,
    output logic                     line_overflow
);

    localparam int IW = $clog2(NUM_SPRITES);
    localparam int CW = $clog2(MAX_PER_LINE + 1);
    localparam int RW = $clog2(SPRITE_H);

    typedef enum logic [1:0] {IDLE, SCAN, READY} state_t;

    state_t state, state_next;

    logic [9:0] sh_x   [NUM_SPRITES];
    logic [9:0] sh_y   [NUM_SPRITES];
    logic [1:0] sh_dir [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] sh_en;

    logic [9:0]    scan_y;
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;

    logic [9:0]    slot_x   [MAX_PER_LINE];
    logic [1:0]    slot_dir [MAX_PER_LINE];
    logic [RW-1:0] slot_row [MAX_PER_LINE];
    logic [6:0]    slot_ent [MAX_PER_LINE];
    logic [MAX_PER_LINE-1:0] slot_vld;

    logic [9:0]  cur_x;
    logic [9:0]  cur_y;
    logic [1:0]  cur_dir;
    logic        cur_en;
    logic [6:0]  cur_ent;
    logic [10:0] cur_dy;
    logic        scan_hit;
    logic        scan_last;
    logic        list_full;

    // Select the sprite under test from the shadow copy.
    always_comb begin
        cur_x   = '0;
        cur_y   = '0;
        cur_dir = '0;
        cur_en  = 1'b0;
        cur_ent = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (idx == IW'(i)) begin
                cur_x   = sh_x[i];
                cur_y   = sh_y[i];
                cur_dir = sh_dir[i];
                cur_en  = sh_en[i];
                cur_ent = (i == 0) ? 7'd1 : 7'(i + 2);
            end
        end
    end

    // A negative offset wraps above SPRITE_H, so one compare covers both bounds.
    assign cur_dy    = {1'b0, scan_y} - {1'b0, cur_y};
    assign scan_hit  = cur_en && (cur_dy < 11'(SPRITE_H));
    assign scan_last = (idx == IW'(NUM_SPRITES - 1));
    assign list_full = (cnt == CW'(MAX_PER_LINE));
    assign sched_busy = (state == SCAN);

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state: a line_start always (re)starts the scan.
    always_comb begin
        state_next = state;
        if (line_start) begin
            state_next = SCAN;
        end else begin
            unique case (state)
                IDLE:    state_next = IDLE;
                SCAN:    state_next = scan_last ? READY : SCAN;
                READY:   state_next = READY;
                default: state_next = IDLE;
            endcase
        end
    end

    // Shadow latch, scan counters, active list and overflow flag.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                sh_x[i]   <= '0;
                sh_y[i]   <= '0;
                sh_dir[i] <= '0;
            end
            sh_en  <= '0;
            scan_y <= '0;
            idx    <= '0;
            cnt    <= '0;
            for (int s = 0; s < MAX_PER_LINE; s++) begin
                slot_x[s]   <= '0;
                slot_dir[s] <= '0;
                slot_row[s] <= '0;
                slot_ent[s] <= '0;
            end
            slot_vld      <= '0;
            line_overflow <= 1'b0;
        end else begin
            if (frame_start) begin
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    sh_x[i]   <= spr_x[10*i +: 10];
                    sh_y[i]   <= spr_y[10*i +: 10];
                    sh_dir[i] <= spr_dir[2*i +: 2];
                end
                sh_en <= spr_en;
            end
            if (state == SCAN && !line_start && scan_hit && list_full)
                line_overflow <= 1'b1;
            else if (frame_start)
                line_overflow <= 1'b0;
            if (line_start) begin
                scan_y   <= line_y;
                idx      <= '0;
                cnt      <= '0;
                slot_vld <= '0;
            end else if (state == SCAN) begin
                idx <= idx + 1'b1;
                if (scan_hit && !list_full) begin
                    for (int s = 0; s < MAX_PER_LINE; s++) begin
                        if (cnt == CW'(s)) begin
                            slot_x[s]   <= cur_x;
                            slot_dir[s] <= cur_dir;
                            slot_row[s] <= cur_dy[RW-1:0];
                            slot_ent[s] <= cur_ent;
                            slot_vld[s] <= 1'b1;
                        end
                    end
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    logic [10:0] dx;
    logic [10:0] dy;
    logic        in_maze;
    logic [10:0] slot_off [MAX_PER_LINE];
    logic [MAX_PER_LINE-1:0] slot_hit;

    assign dx = {1'b0, DrawX} - 11'(MAZE_X0);
    assign dy = {1'b0, DrawY} - 11'(MAZE_Y0);
    assign in_maze = (dx < 11'(MAZE_W)) && (dy < 11'(MAZE_H));

    // Horizontal hit test of every list slot against the current pixel.
    always_comb begin
        for (int s = 0; s < MAX_PER_LINE; s++) begin
            slot_off[s] = {1'b0, DrawX} - {1'b0, slot_x[s]};
            slot_hit[s] = slot_vld[s] && (slot_off[s] < 11'(SPRITE_W));
        end
    end

    logic [6:0] p_ent;
    logic [9:0] p_sax;
    logic [9:0] p_say;
    logic [9:0] p_max;
    logic [9:0] p_may;
    logic [1:0] p_dir;

    // Pixel resolve; slots are walked high to low so the lowest index wins.
    always_comb begin
        p_ent = '0;
        p_sax = '0;
        p_say = '0;
        p_max = '0;
        p_may = '0;
        p_dir = '0;
        if (in_maze) begin
            p_ent = 7'd2;
            p_max = dx[9:0];
            p_may = dy[9:0];
            if (state == READY) begin
                for (int s = MAX_PER_LINE - 1; s >= 0; s--) begin
                    if (slot_hit[s]) begin
                        p_ent = slot_ent[s];
                        p_sax = slot_off[s][9:0];
                        p_say = 10'(slot_row[s]);
                        p_dir = slot_dir[s];
                    end
                end
            end
        end
    end

    // Register the pixel outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            entity      <= '0;
            spriteAddrX <= '0;
            spriteAddrY <= '0;
            mazeAddrX   <= '0;
            mazeAddrY   <= '0;
            direction   <= '0;
        end else begin
            entity      <= p_ent;
            spriteAddrX <= p_sax;
            spriteAddrY <= p_say;
            mazeAddrX   <= p_max;
            mazeAddrY   <= p_may;
            direction   <= p_dir;
        end
    end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Scoreboard bench for sprite_line_scheduler: pixel probes queue
// hand-computed expectations that a monitor checks one cycle later.
module tb_sprite_line_scheduler;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_start = 1'b0;
    logic        line_start = 1'b0;
    logic [9:0]  line_y = '0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic [49:0] spr_x = '0;
    logic [49:0] spr_y = '0;
    logic [9:0]  spr_dir = '0;
    logic [4:0]  spr_en = '0;
    logic [6:0]  entity;
    logic [9:0]  spriteAddrX;
    logic [9:0]  spriteAddrY;
    logic [9:0]  mazeAddrX;
    logic [9:0]  mazeAddrY;
    logic [1:0]  direction;
    logic        sched_busy;
    logic        line_overflow;

    sprite_line_scheduler dut (
        .Clk(Clk),
        .Reset(Reset),
        .frame_start(frame_start),
        .line_start(line_start),
        .line_y(line_y),
        .DrawX(DrawX),
        .DrawY(DrawY),
        .spr_x(spr_x),
        .spr_y(spr_y),
        .spr_dir(spr_dir),
        .spr_en(spr_en),
        .entity(entity),
        .spriteAddrX(spriteAddrX),
        .spriteAddrY(spriteAddrY),
        .mazeAddrX(mazeAddrX),
        .mazeAddrY(mazeAddrY),
        .direction(direction),
        .sched_busy(sched_busy),
        .line_overflow(line_overflow)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string      name;
        logic [6:0] ent;
        logic [9:0] sax;
        logic [9:0] say;
        logic [9:0] max;
        logic [9:0] may;
        logic [1:0] dir;
        logic       ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    logic probe = 1'b0;
    logic probe_q = 1'b0;

    always @(posedge Clk) probe_q <= probe;

    // Monitor: one registered pixel result per probe.
    always @(negedge Clk) begin
        if (probe_q) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL no_expectation: output present with empty queue");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (entity !== e.ent || spriteAddrX !== e.sax ||
                    spriteAddrY !== e.say || mazeAddrX !== e.max ||
                    mazeAddrY !== e.may || direction !== e.dir ||
                    line_overflow !== e.ovf) begin
                    failures++;
                    $display("FAIL %s: got ent=%0d sx=%0d sy=%0d mx=%0d my=%0d dir=%0d ovf=%0d want ent=%0d sx=%0d sy=%0d mx=%0d my=%0d dir=%0d ovf=%0d",
                             e.name, entity, spriteAddrX, spriteAddrY,
                             mazeAddrX, mazeAddrY, direction, line_overflow,
                             e.ent, e.sax, e.say, e.max, e.may, e.dir, e.ovf);
                end
            end
        end
    end

    task automatic pix(input string name, input int x, input int y,
                       input int ent, input int sax, input int say,
                       input int max, input int may, input int dir,
                       input int ovf);
        exp_t e;
        @(negedge Clk);
        DrawX = 10'(x);
        DrawY = 10'(y);
        e.name = name;
        e.ent = 7'(ent);
        e.sax = 10'(sax);
        e.say = 10'(say);
        e.max = 10'(max);
        e.may = 10'(may);
        e.dir = 2'(dir);
        e.ovf = 1'(ovf);
        exp_q.push_back(e);
        probe = 1'b1;
        @(negedge Clk);
        probe = 1'b0;
    endtask

    task automatic set_spr(input int i, input int x, input int y,
                           input int dir, input int en);
        spr_x[10*i +: 10] = 10'(x);
        spr_y[10*i +: 10] = 10'(y);
        spr_dir[2*i +: 2] = 2'(dir);
        spr_en[i] = 1'(en);
    endtask

    task automatic clear_spr();
        for (int i = 0; i < 5; i++) set_spr(i, 0, 0, 0, 0);
    endtask

    task automatic frame();
        @(negedge Clk);
        frame_start = 1'b1;
        @(negedge Clk);
        frame_start = 1'b0;
    endtask

    task automatic start_line(input int ly);
        @(negedge Clk);
        line_start = 1'b1;
        line_y = 10'(ly);
        @(negedge Clk);
        line_start = 1'b0;
    endtask

    task automatic check_busy(input string name, input int want);
        int n;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (sched_busy) n++;
            else break;
            @(negedge Clk);
        end
        checks++;
        if (n != want) begin
            failures++;
            $display("FAIL %s: busy cycles got %0d want %0d", name, n, want);
        end
    endtask

    task automatic check_bit(input string name, input logic got,
                             input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    initial begin
        // Reset state: registered outputs held at zero.
        pix("reset_out", 100, 10, 0, 0, 0, 0, 0, 0, 0);
        check_bit("reset_busy", sched_busy, 1'b0);
        @(negedge Clk);
        Reset = 1'b0;
        pix("idle_bg", 100, 10, 2, 0, 0, 4, 10, 0, 0);
        check_bit("idle_busy", sched_busy, 1'b0);

        // Single pacman.
        clear_spr();
        set_spr(0, 200, 40, 3, 1);
        frame();
        start_line(45);
        check_busy("scan_len", 5);
        pix("pac_hit", 205, 45, 1, 5, 5, 109, 45, 3, 0);
        pix("pac_right_edge", 215, 45, 1, 15, 5, 119, 45, 3, 0);
        pix("pac_past", 216, 45, 2, 0, 0, 120, 45, 0, 0);
        pix("pac_before", 199, 45, 2, 0, 0, 103, 45, 0, 0);

        // Priority pacman over blinky.
        set_spr(0, 300, 100, 0, 1);
        set_spr(1, 300, 100, 1, 1);
        frame();
        start_line(100);
        check_busy("scan_len2", 5);
        pix("prio_pac", 300, 100, 1, 0, 0, 204, 100, 0, 0);
        set_spr(0, 300, 100, 0, 0);
        frame();
        start_line(100);
        check_busy("scan_len3", 5);
        pix("prio_blinky", 300, 100, 3, 0, 0, 204, 100, 1, 0);

        // Overflow: five sprites on one line.
        for (int i = 0; i < 5; i++) set_spr(i, 120 + 20 * i, 50, i % 4, 1);
        frame();
        start_line(50);
        check_busy("scan_len4", 5);
        pix("ovf_clyde_drop", 205, 50, 2, 0, 0, 109, 50, 0, 1);
        pix("ovf_inky", 185, 50, 5, 5, 0, 89, 50, 3, 1);
        start_line(65);
        check_busy("scan_len5", 5);
        pix("last_row", 125, 65, 1, 5, 15, 29, 65, 0, 1);
        start_line(66);
        check_busy("scan_len6", 5);
        pix("below_sprite", 125, 66, 2, 0, 0, 29, 66, 0, 1);
        for (int i = 0; i < 5; i++) set_spr(i, 120 + 20 * i, 300, 0, 1);
        frame();
        pix("ovf_cleared", 100, 300, 2, 0, 0, 4, 300, 0, 0);

        // Scan restart and live-input isolation.
        clear_spr();
        set_spr(0, 200, 60, 1, 1);
        set_spr(1, 250, 61, 3, 1);
        frame();
        start_line(60);
        @(negedge Clk);
        line_start = 1'b1;
        line_y = 10'd61;
        @(negedge Clk);
        line_start = 1'b0;
        check_busy("restart_len", 5);
        set_spr(0, 400, 61, 0, 0);
        pix("restart_pac", 201, 61, 1, 1, 1, 105, 61, 1, 0);
        pix("restart_blinky", 251, 61, 3, 1, 0, 155, 61, 3, 0);
        start_line(61);
        check_busy("scan_len7", 5);
        pix("live_ignored", 201, 61, 1, 1, 1, 105, 61, 1, 0);

        // Outside maze and sprite straddling the left edge.
        clear_spr();
        set_spr(0, 40, 0, 2, 1);
        frame();
        start_line(5);
        check_busy("scan_len8", 5);
        pix("outside", 50, 5, 0, 0, 0, 0, 0, 0, 0);
        pix("maze_edge", 96, 5, 2, 0, 0, 0, 5, 0, 0);

        // Reset during a scan.
        start_line(5);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check_bit("reset_mid_scan", sched_busy, 1'b0);
        pix("after_reset", 100, 10, 2, 0, 0, 4, 10, 0, 0);

        repeat (3) @(negedge Clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
